motor_duty_ramp: RTL and testbench
==================================

// Module: motor_duty_ramp
// PURPOSE
//  Slew-limited front end for the 8-bit PWM generator in the motor drive path.
//  - Takes a signed motor command from the steering/control logic.
//  - Produces an 8-bit magnitude duty (feeds the PWM duty input) and a direction bit.
//  - Ramps duty toward the target at a fixed rate.
//  - On a sign change, decelerates to zero and dwells at zero before flipping direction.
// PARAMETERS
//  TICK_DIV    1024  clocks per ramp tick (>=2); prescaler period
//  STEP        4     duty change per ramp tick (1..255)
//  DEAD_TICKS  8     ramp ticks held at duty 0 before a direction flip (>=1)
// PORTS
//  clk        in   1  system clock; all state updates on posedge
//  rst_n      in   1  reset, synchronous, active-low
//  cmd        in   9  signed target, two's complement; positive = forward
//  cmd_vld    in   1  1-cycle strobe: load cmd as new target (always accepted)
//  estop      in   1  level: force duty 0 and clear target while high
//  duty       out  8  unsigned duty to PWM stage (registered)
//  fwd        out  1  direction: 1 = forward, 0 = reverse (registered)
//  at_target  out  1  high while duty == |target| and no flip is pending (registered)
// BEHAVIOUR
//  Reset (rst_n low at posedge):
//   - duty=0, fwd=1, at_target=1
//   - tgt_mag=0, tgt_fwd=1, prescaler=0, dead count=0, state=HOLD
//  Target load (cmd_vld=1):
//   - tgt_mag=|cmd|; cmd=-256 saturates to 255.
//   - tgt_fwd=(cmd>0). If cmd==0, tgt_fwd keeps its old value, so zero never forces a flip.
//   - The new target is first used in the cycle after load.
//   - If a tick coincides with the load, that tick uses the old target.
//  Prescaler:
//   - Counts 0..TICK_DIV-1 and wraps; free-running.
//   - tick=1 in the cycle where count==TICK_DIV-1.
//   - duty changes only at the posedge ending a tick cycle.
//  Step rule (move duty toward goal g):
//   - If |g-duty| <= STEP, duty=g; else duty moves STEP toward g.
//   - Computed 9 bits wide; duty never wraps below 0 or above 255.
//  States:
//   HOLD:
//    - duty==tgt_mag and fwd==tgt_fwd.
//    - Leave when the target changes: to RAMP if tgt_fwd==fwd or duty==0, else to DECEL.
//   RAMP:
//    - On each tick, step toward tgt_mag.
//    - Go to HOLD when duty==tgt_mag.
//    - If tgt_fwd!=fwd: go to DECEL when duty>0, else to DEAD.
//   DECEL:
//    - On each tick, step toward 0.
//    - At duty==0, go to DEAD and clear the dead count.
//    - If tgt_fwd returns to fwd, go to RAMP (no dwell).
//   DEAD:
//    - duty held 0; dead count increments on each tick.
//    - When count reaches DEAD_TICKS: fwd<=tgt_fwd, go to RAMP (or HOLD if tgt_mag==0).
//    - If tgt_fwd==fwd while in DEAD: go to RAMP immediately; fwd unchanged.
//  Direction integrity: fwd changes only on the DEAD exit, and only when duty==0.
//  estop:
//   - At each posedge with estop=1: duty=0, tgt_mag=0, state=HOLD, dead count cleared.
//   - fwd is unchanged.
//   - cmd_vld is ignored while estop=1.
//   - After estop drops, the block stays at 0 until a new cmd_vld.
//  Priority: rst_n > estop > cmd_vld > tick.
//  at_target is registered: it is 1 in the cycle after duty reaches tgt_mag with fwd==tgt_fwd.
//  Reset mid-operation: every register takes its reset value at that edge; no partial ramp survives.
// TESTING  (TICK_DIV=4, STEP=4, DEAD_TICKS=2 unless noted)
//  1. Reset, then cmd=+10 -> duty 0,4,8,10 on successive ticks; fwd=1; at_target=1 one cycle after 10.
//  2. At duty=12 fwd, cmd=-6 -> duty 8,4,0; then 2 ticks at 0 with fwd=1; then fwd=0; duty 4,6; at_target=1.
//  3. cmd=-256 (9'h100) -> target 255 reverse; duty saturates at 255; no wrap; at_target=1.
//  4. estop asserted at duty 40 -> duty=0 next cycle, fwd held; estop drops -> duty stays 0 until cmd_vld.
//  5. During DEAD (fwd=1, target reverse), cmd=+50 -> exits DEAD, fwd stays 1, ramps 4,8..48,50.
//  6. Mid-ramp, rst_n low for 1 cycle -> duty=0, fwd=1, at_target=1 next edge; cmd_vld coinciding with tick uses old target.

Source files
------------

// File: rtl/motor_duty_ramp.sv
// motor_duty_ramp: slew-limited duty/direction front end for the 8-bit PWM stage.
// A signed command sets a target magnitude and direction. Duty moves toward that
// target by a fixed step on each prescaler tick. A reversal first decelerates to
// zero, then holds zero for a dead time, and only then flips direction.
//
// Handshake: cmd_vld is a one-cycle strobe that is always accepted (there is no
// ready signal). The new target takes effect from the cycle after the strobe.
module motor_duty_ramp #(
  parameter int TICK_DIV   = 1024,  // clocks per ramp tick (>=2)
  parameter int STEP       = 4,     // duty change per tick (1..255)
  parameter int DEAD_TICKS = 8      // ticks held at zero before a flip (>=1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] cmd,
  input  logic       cmd_vld,
  input  logic       estop,
  output logic [7:0] duty,
  output logic       fwd,
  output logic       at_target,
  output logic [1:0] state_dbg
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEAD_TICKS + 1);
  localparam logic [8:0] STEP9 = 9'(STEP);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_RAMP  = 2'd1,
    S_DECEL = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  state_t        state_q;
  logic [7:0]    duty_q;
  logic          fwd_q;
  logic          at_target_q;
  logic [DW-1:0] dead_q;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    tgt_mag_q, tgt_mag_d;
  logic          tgt_fwd_q, tgt_fwd_d;

  logic          tick;
  logic [8:0]    cmd_abs;
  logic [7:0]    cmd_mag;
  logic          at_now;

  // Moves cur one step toward goal. The arithmetic is 9 bits wide so it can
  // never wrap past 0 or 255.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] goal);
    logic [8:0] diff;
    logic [8:0] nxt;
    if (goal >= cur) begin
      diff = {1'b0, goal} - {1'b0, cur};
      nxt  = (diff <= STEP9) ? {1'b0, goal} : ({1'b0, cur} + STEP9);
    end else begin
      diff = {1'b0, cur} - {1'b0, goal};
      nxt  = (diff <= STEP9) ? {1'b0, goal} : ({1'b0, cur} - STEP9);
    end
    return nxt[7:0];
  endfunction

  // Prescaler terminal count marks the tick cycle.
  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // Command magnitude. -256 gives 256, which saturates to 255.
  always_comb begin
    cmd_abs = cmd[8] ? (~cmd + 9'd1) : cmd;
    cmd_mag = cmd_abs[8] ? 8'hFF : cmd_abs[7:0];
  end

  // Next prescaler count: free-running, wraps at TICK_DIV-1.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Next target. estop clears the magnitude and blocks loads. A zero command
  // keeps the old direction, so it never requests a flip.
  always_comb begin
    tgt_mag_d = tgt_mag_q;
    tgt_fwd_d = tgt_fwd_q;
    if (estop) begin
      tgt_mag_d = 8'd0;
    end else if (cmd_vld) begin
      tgt_mag_d = cmd_mag;
      if (cmd != 9'd0) tgt_fwd_d = ~cmd[8];
    end
  end

  // Registers the prescaler and the target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q   <= '0;
      tgt_mag_q <= 8'd0;
      tgt_fwd_q <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      tgt_mag_q <= tgt_mag_d;
      tgt_fwd_q <= tgt_fwd_d;
    end
  end

  // Settled condition from the current registers. It is registered, so
  // at_target lags duty by one cycle.
  assign at_now = (duty_q == tgt_mag_q) && (fwd_q == tgt_fwd_q);

  // Ramp FSM: it owns duty, direction, dead count and at_target. It always
  // uses the registered (old) target, so a load on a tick cycle does not
  // affect that tick. fwd changes only when leaving DEAD, where duty is 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_HOLD;
      duty_q      <= 8'd0;
      fwd_q       <= 1'b1;
      at_target_q <= 1'b1;
      dead_q      <= '0;
    end else if (estop) begin
      state_q     <= S_HOLD;
      duty_q      <= 8'd0;
      dead_q      <= '0;
      at_target_q <= at_now;
    end else begin
      at_target_q <= at_now;
      case (state_q)
        S_HOLD: begin
          if ((tgt_mag_q != duty_q) || (tgt_fwd_q != fwd_q)) begin
            if ((tgt_fwd_q == fwd_q) || (duty_q == 8'd0)) state_q <= S_RAMP;
            else                                         state_q <= S_DECEL;
          end
        end
        S_RAMP: begin
          if (tgt_fwd_q != fwd_q) begin
            if (duty_q != 8'd0) begin
              state_q <= S_DECEL;
            end else begin
              state_q <= S_DEAD;
              dead_q  <= '0;
            end
          end else if (duty_q == tgt_mag_q) begin
            state_q <= S_HOLD;
          end else if (tick) begin
            duty_q <= step_toward(duty_q, tgt_mag_q);
          end
        end
        S_DECEL: begin
          if (tgt_fwd_q == fwd_q) begin
            state_q <= S_RAMP;
          end else if (duty_q == 8'd0) begin
            state_q <= S_DEAD;
            dead_q  <= '0;
          end else if (tick) begin
            duty_q <= step_toward(duty_q, 8'd0);
          end
        end
        S_DEAD: begin
          if (tgt_fwd_q == fwd_q) begin
            state_q <= S_RAMP;
            dead_q  <= '0;
          end else if (tick) begin
            if (dead_q == DW'(DEAD_TICKS - 1)) begin
              fwd_q   <= tgt_fwd_q;
              dead_q  <= '0;
              state_q <= (tgt_mag_q == 8'd0) ? S_HOLD : S_RAMP;
            end else begin
              dead_q <= dead_q + DW'(1);
            end
          end
        end
        default: begin
          state_q <= S_HOLD;
          duty_q  <= 8'd0;
          dead_q  <= '0;
        end
      endcase
    end
  end

  assign duty      = duty_q;
  assign fwd       = fwd_q;
  assign at_target = at_target_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_motor_duty_ramp.sv
// Directed bench for motor_duty_ramp with TICK_DIV=4, STEP=4, DEAD_TICKS=2.
// The prescaler restarts at 0 on every reset, so a tick occurs in each cycle n
// with n%4==3, and duty moves at posedges 4, 8, 12, ...
// cyc counts the posedges since the last reset release. All driving and
// sampling happens at negedges.
module tb_motor_duty_ramp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] cmd;
  logic       cmd_vld;
  logic       estop;
  logic [7:0] duty;
  logic       fwd;
  logic       at_target;
  logic [1:0] state_dbg;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  motor_duty_ramp #(.TICK_DIV(4), .STEP(4), .DEAD_TICKS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd),
    .cmd_vld   (cmd_vld),
    .estop     (estop),
    .duty      (duty),
    .fwd       (fwd),
    .at_target (at_target),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic go_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic load(input logic [8:0] c);
    cmd     = c;
    cmd_vld = 1'b1;
    @(negedge clk);
    cyc++;
    cmd_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    cmd_vld = 1'b0;
    estop   = 1'b0;
    cmd     = 9'd0;
    repeat (2) @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_fwd", fwd, 1);
    chk("rst_at_target", at_target, 1);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    rst_n   = 1'b0;
    cmd     = 9'd0;
    cmd_vld = 1'b0;
    estop   = 1'b0;

    // Forward ramp to +10
    do_reset();
    load(9'd10);
    go_to(3);   chk("t1_duty_c3", duty, 0);
    go_to(4);   chk("t1_duty_c4", duty, 4);  chk("t1_fwd", fwd, 1);
    go_to(8);   chk("t1_duty_c8", duty, 8);
    go_to(12);  chk("t1_duty_c12", duty, 10); chk("t1_at_c12", at_target, 0);
    go_to(13);  chk("t1_at_c13", at_target, 1);

    // Up to 12, then reverse to -6 through DECEL and DEAD
    load(9'd12);
    go_to(16);  chk("t2_duty12", duty, 12);
    go_to(17);  load(-9'sd6);
    go_to(20);  chk("t2_dec8", duty, 8);
    go_to(24);  chk("t2_dec4", duty, 4);
    go_to(28);  chk("t2_dec0", duty, 0); chk("t2_fwd_c28", fwd, 1);
    go_to(35);  chk("t2_dead_fwd", fwd, 1); chk("t2_dead_duty", duty, 0);
    go_to(36);  chk("t2_flip_fwd", fwd, 0); chk("t2_flip_duty", duty, 0);
    go_to(40);  chk("t2_rev4", duty, 4);
    go_to(44);  chk("t2_rev6", duty, 6); chk("t2_at_c44", at_target, 0);
    go_to(45);  chk("t2_at_c45", at_target, 1);

    // -256 saturates to 255 reverse
    load(9'h100);
    go_to(48);  chk("t3_duty10", duty, 10); chk("t3_fwd", fwd, 0);
    go_to(292); chk("t3_duty254", duty, 254);
    go_to(296); chk("t3_duty255", duty, 255);
    go_to(297); chk("t3_at", at_target, 1);
    go_to(320); chk("t3_nowrap", duty, 255); chk("t3_fwd_hold", fwd, 0);

    // estop in reverse at full duty; the cmd_vld in the same cycle is ignored
    estop   = 1'b1;
    cmd     = 9'd100;
    cmd_vld = 1'b1;
    @(negedge clk); cyc++;
    cmd_vld = 1'b0;
    chk("t4r_duty0", duty, 0); chk("t4r_fwd", fwd, 0);
    go_to(322); estop = 1'b0;
    go_to(340); chk("t4r_stay0", duty, 0); chk("t4r_fwd_stay", fwd, 0);
    chk("t4r_at", at_target, 1);

    // +8 from zero duty in reverse: DEAD dwell, then flip, then ramp
    load(9'd8);
    go_to(347); chk("t4r_pre_flip", fwd, 0);
    go_to(348); chk("t4r_flip", fwd, 1); chk("t4r_flip_duty", duty, 0);
    go_to(352); chk("t4r_d4", duty, 4);
    go_to(356); chk("t4r_d8", duty, 8);

    // estop at duty 40 forward
    do_reset();
    load(9'd50);
    go_to(40);  chk("t4_duty40", duty, 40);
    estop = 1'b1;
    go_to(41);  chk("t4_estop_duty", duty, 0); chk("t4_estop_fwd", fwd, 1);
    go_to(42);  estop = 1'b0;
    go_to(60);  chk("t4_stay0", duty, 0); chk("t4_at", at_target, 1);

    // A forward command during DEAD leaves DEAD without a flip
    do_reset();
    load(-9'sd4);
    go_to(4);   load(9'd50);
    go_to(8);   chk("t5_fwd", fwd, 1); chk("t5_duty4", duty, 4);
    go_to(52);  chk("t5_duty48", duty, 48); chk("t5_fwd_late", fwd, 1);
    go_to(56);  chk("t5_duty50", duty, 50);
    go_to(57);  chk("t5_at", at_target, 1);

    // A load on a tick cycle: the tick still uses the old target
    do_reset();
    load(9'd20);
    go_to(8);   chk("t6_duty8", duty, 8);
    go_to(11);  load(9'd6);
    chk("t6_old_tgt", duty, 12);
    go_to(16);  chk("t6_down8", duty, 8);
    go_to(20);  chk("t6_down6", duty, 6); chk("t6_at_c20", at_target, 0);
    go_to(21);  chk("t6_at_c21", at_target, 1);

    // A one-cycle reset mid-ramp
    load(9'd100);
    go_to(26);  chk("t6_ramp10", duty, 10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_duty", duty, 0); chk("t6_rst_fwd", fwd, 1); chk("t6_rst_at", at_target, 1);
    rst_n = 1'b1;
    cyc   = 0;
    go_to(12);  chk("t6_no_resume", duty, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
